// File: rtl/program_loader_if.sv
// Byte-stream receive handshake and memory write bus shared by the program loader
// and its environment (UART receiver on one side, instruction/data memory on the other).
interface program_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Loads a host program into ControlUnit memory from a UART byte stream
// (16-bit LE word count, then LE 32-bit words) and enables the core when done.
module program_loader #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  program_loader_if.master      bus,
  output logic                  top_en,
  output logic                  busy,
  output logic                  err,
  output logic [15:0]           words_loaded
);

  localparam logic [2:0] HDR_LO = 3'd0;
  localparam logic [2:0] HDR_HI = 3'd1;
  localparam logic [2:0] CHECK  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERROR  = 3'd6;

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       MAX_N = 32'(MAX_WORDS);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [15:0]       n_words;
  logic [1:0]        idx;
  logic [DATA_W-1:0] word_asm;
  logic [ADDR_W-1:0] addr;
  logic              xfer;
  logic              too_big;
  logic              last_word;

  function automatic logic [DATA_W-1:0] put_lane(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        lane,
    input logic [7:0]        b
  );
    logic [DATA_W-1:0] r;
    r = word;
    r[8*lane +: 8] = b;
    return r;
  endfunction

  assign bus.rx_ready = (state == HDR_LO) || (state == HDR_HI) || (state == DATA);
  assign xfer         = bus.rx_valid && bus.rx_ready;
  assign too_big      = {16'd0, n_words} > MAX_N;
  assign last_word    = (words_loaded + 16'd1) == n_words;

  // A WRITE cycle that coincides with rst must not reach memory.
  assign bus.mem_we    = (state == WRITE) && !rst;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = word_asm;

  always_comb begin
    state_nxt = state;
    case (state)
      HDR_LO: if (xfer) state_nxt = HDR_HI;
      HDR_HI: if (xfer) state_nxt = CHECK;
      CHECK: begin
        if (n_words == 16'd0) state_nxt = DONE;
        else if (too_big)     state_nxt = ERROR;
        else                  state_nxt = DATA;
      end
      DATA:   if (xfer && idx == 2'd3) state_nxt = WRITE;
      WRITE:  state_nxt = last_word ? DONE : DATA;
      DONE:   state_nxt = DONE;
      ERROR:  state_nxt = ERROR;
      default: state_nxt = HDR_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HDR_LO;
      n_words      <= 16'd0;
      idx          <= 2'd0;
      word_asm     <= '0;
      addr         <= BASE;
      words_loaded <= 16'd0;
      top_en       <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        HDR_LO: begin
          if (xfer) begin
            n_words[7:0] <= bus.rx_data;
            busy         <= 1'b1;
          end
        end
        HDR_HI: if (xfer) n_words[15:8] <= bus.rx_data;
        CHECK:  idx <= 2'd0;
        DATA: begin
          if (xfer) begin
            word_asm <= put_lane(word_asm, idx, bus.rx_data);
            idx      <= idx + 2'd1;
          end
        end
        WRITE: begin
          // Address wraps naturally at 2^ADDR_W; MAX_WORDS bounds the load.
          addr         <= addr + ADDR_W'(1);
          words_loaded <= words_loaded + 16'd1;
        end
        default: ;
      endcase
      if (state != DONE && state_nxt == DONE) begin
        top_en <= 1'b1;
        busy   <= 1'b0;
      end
      if (state != ERROR && state_nxt == ERROR) begin
        err  <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal, zero-length, oversize, gapped,
// reset-mid-load and post-DONE traffic scenarios with hand-computed expectations.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        top_en, busy, err;
  logic [15:0] words_loaded;
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  int          base;
  logic [15:0] log_addr [0:31];
  logic [31:0] log_data [0:31];

  program_loader_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  program_loader #(.ADDR_W(16), .DATA_W(32), .BASE_ADDR(0), .MAX_WORDS(4096)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .top_en       (top_en),
    .busy         (busy),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      if (we_cnt < 32) begin
        log_addr[we_cnt] <= bus.mem_addr;
        log_data[we_cnt] <= bus.mem_wdata;
      end
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Holds the byte until it is accepted; returns 1 time unit after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && t < 50) begin
      tick();
      t++;
    end
    if (!bus.rx_ready) chk_eq("rx_ready_timeout", 64'(bus.rx_ready), 64'd1);
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    chk_eq("rst_top_en", 64'(top_en), 64'd0);
    chk_eq("rst_busy", 64'(busy), 64'd0);
    chk_eq("rst_err", 64'(err), 64'd0);
    chk_eq("rst_words", 64'(words_loaded), 64'd0);
    chk_eq("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk_eq("rst_we", 64'(bus.mem_we), 64'd0);
    chk_eq("rst_rdy", 64'(bus.rx_ready), 64'd1);

    // Normal two-word load
    base = we_cnt;
    send_byte(8'h02);
    chk_eq("norm_busy", 64'(busy), 64'd1);
    send_byte(8'h00);
    chk_eq("norm_check_rdy", 64'(bus.rx_ready), 64'd0);
    send_word(32'h12345678);
    chk_eq("norm_we0", 64'(bus.mem_we), 64'd1);
    chk_eq("norm_addr0", 64'(bus.mem_addr), 64'd0);
    chk_eq("norm_data0", 64'(bus.mem_wdata), 64'h12345678);
    send_word(32'hDEADBEEF);
    chk_eq("norm_we1", 64'(bus.mem_we), 64'd1);
    chk_eq("norm_addr1", 64'(bus.mem_addr), 64'd1);
    chk_eq("norm_data1", 64'(bus.mem_wdata), 64'hDEADBEEF);
    chk_eq("norm_top_en_early", 64'(top_en), 64'd0);
    tick();
    chk_eq("norm_top_en", 64'(top_en), 64'd1);
    chk_eq("norm_words", 64'(words_loaded), 64'd2);
    chk_eq("norm_busy_done", 64'(busy), 64'd0);
    chk_eq("norm_err", 64'(err), 64'd0);
    chk_eq("norm_we_cnt", 64'(we_cnt - base), 64'd2);
    chk_eq("norm_log_addr1", 64'(log_addr[base+1]), 64'd1);
    chk_eq("norm_log_data0", 64'(log_data[base]), 64'h12345678);

    // Zero-length load
    do_reset();
    base = we_cnt;
    send_byte(8'h00);
    send_byte(8'h00);
    chk_eq("zero_top_en_check", 64'(top_en), 64'd0);
    tick();
    chk_eq("zero_top_en", 64'(top_en), 64'd1);
    chk_eq("zero_busy", 64'(busy), 64'd0);
    chk_eq("zero_we_cnt", 64'(we_cnt - base), 64'd0);

    // Oversize header N = 4097
    do_reset();
    base = we_cnt;
    send_byte(8'h01);
    send_byte(8'h10);
    tick();
    chk_eq("over_err", 64'(err), 64'd1);
    chk_eq("over_top_en", 64'(top_en), 64'd0);
    chk_eq("over_rdy", 64'(bus.rx_ready), 64'd0);
    chk_eq("over_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 8; i++) begin
      bus.rx_data  = 8'(8'hA0 + i);
      bus.rx_valid = 1'b1;
      tick();
    end
    bus.rx_valid = 1'b0;
    chk_eq("over_we_cnt", 64'(we_cnt - base), 64'd0);
    chk_eq("over_err_sticky", 64'(err), 64'd1);

    // Gapped input, N = 1, three idle cycles after each byte
    do_reset();
    base = we_cnt;
    send_byte(8'h01);
    for (int g = 0; g < 3; g++) begin
      chk_eq("gap_hdr_rdy", 64'(bus.rx_ready), 64'd1);
      tick();
    end
    send_byte(8'h00);
    for (int g = 0; g < 3; g++) begin
      chk_eq("gap_check_rdy", 64'(bus.rx_ready), (g == 0) ? 64'd0 : 64'd1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(8'hA1 + 8'h11 * i));
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          chk_eq("gap_data_rdy", 64'(bus.rx_ready), 64'd1);
          chk_eq("gap_data_we", 64'(bus.mem_we), 64'd0);
          tick();
        end
      end
    end
    chk_eq("gap_we", 64'(bus.mem_we), 64'd1);
    chk_eq("gap_write_rdy", 64'(bus.rx_ready), 64'd0);
    chk_eq("gap_data", 64'(bus.mem_wdata), 64'hD4C3B2A1);
    tick();
    chk_eq("gap_top_en", 64'(top_en), 64'd1);
    chk_eq("gap_we_cnt", 64'(we_cnt - base), 64'd1);

    // Reset coincident with a WRITE cycle
    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    base = we_cnt;
    send_word(32'h55667788);
    rst = 1'b1;
    #1;
    chk_eq("rstw_we", 64'(bus.mem_we), 64'd0);
    tick();
    rst = 1'b0;
    chk_eq("rstw_we_cnt", 64'(we_cnt - base), 64'd0);
    chk_eq("rstw_words", 64'(words_loaded), 64'd0);
    chk_eq("rstw_addr", 64'(bus.mem_addr), 64'd0);

    // Reset mid-word then fresh load
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h12345678);
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    chk_eq("mid_top_en", 64'(top_en), 64'd0);
    chk_eq("mid_busy", 64'(busy), 64'd0);
    chk_eq("mid_err", 64'(err), 64'd0);
    chk_eq("mid_words", 64'(words_loaded), 64'd0);
    chk_eq("mid_addr", 64'(bus.mem_addr), 64'd0);
    chk_eq("mid_we", 64'(bus.mem_we), 64'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h44332211);
    chk_eq("mid_new_we", 64'(bus.mem_we), 64'd1);
    chk_eq("mid_new_addr", 64'(bus.mem_addr), 64'd0);
    chk_eq("mid_new_data", 64'(bus.mem_wdata), 64'h44332211);
    tick();
    chk_eq("mid_new_top_en", 64'(top_en), 64'd1);
    chk_eq("mid_new_words", 64'(words_loaded), 64'd1);

    // Post-DONE traffic
    base = we_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.rx_data  = 8'(8'h30 + i);
      bus.rx_valid = 1'b1;
      #1;
      chk_eq("post_rdy", 64'(bus.rx_ready), 64'd0);
      tick();
    end
    bus.rx_valid = 1'b0;
    chk_eq("post_we_cnt", 64'(we_cnt - base), 64'd0);
    chk_eq("post_top_en", 64'(top_en), 64'd1);
    chk_eq("post_words", 64'(words_loaded), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
